// File: rtl/axil_bram_pkg.sv
// ============================================================================
// axil_bram_pkg : shared types and constants for the AXI4-Lite BRAM controller
// Rev 1.0
// ============================================================================
`default_nettype none

package axil_bram_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RCAP  = 3'd4,
    S_RRESP = 3'd5
  } state_e;

  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } rr_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         WORD_BYTES  = 4;

endpackage

`default_nettype wire

// File: rtl/axil_bram_ctrl.sv
// ============================================================================
// axil_bram_ctrl : AXI4-Lite slave turning single register accesses into BRAM cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_bram_ctrl
  import axil_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BYTES  = 4096,
  parameter int BRAM_AW    = 32
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [BRAM_AW-1:0]    bram_a,
  output logic [31:0]           bram_di,
  input  logic [31:0]           bram_do
);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 64'(addr) < 64'(MEM_BYTES);
  endfunction

  function automatic logic [BRAM_AW-1:0] word_addr(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] aligned;
    aligned = addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
    return BRAM_AW'(aligned);
  endfunction

  state_e               state_q, state_d;
  rr_e                  rr_q, rr_d;
  logic                 err_q, err_d;
  logic                 wr_rdy_q, wr_rdy_d;
  logic                 ar_rdy_q, ar_rdy_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 en_q, en_d;
  logic [3:0]           we_q, we_d;
  logic [BRAM_AW-1:0]   a_q, a_d;
  logic [31:0]          di_q, di_d;

  logic wr_cand, rd_cand, pick_wr, pick_rd, arm;

  assign wr_cand = awvalid & wvalid;
  assign rd_cand = arvalid;
  // On a tie, grant the channel that was not granted last time.
  assign pick_wr = wr_cand & (~rd_cand | (rr_q == RR_READ));
  assign pick_rd = rd_cand & (~wr_cand | (rr_q == RR_WRITE));

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    err_d    = err_q;
    wr_rdy_d = 1'b0;
    ar_rdy_d = 1'b0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    en_d     = 1'b0;
    we_d     = 4'h0;
    a_d      = a_q;
    di_d     = di_q;
    arm      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready was raised last cycle; the handshake completes at this edge.
        if (wr_rdy_q) begin
          if (wr_cand) begin
            state_d = S_WR;
            err_d   = ~in_range(awaddr);
            en_d    = in_range(awaddr);
            we_d    = in_range(awaddr) ? wstrb : 4'h0;
            a_d     = word_addr(awaddr);
            di_d    = wdata;
          end
        end else if (ar_rdy_q) begin
          if (rd_cand) begin
            state_d = S_RD;
            err_d   = ~in_range(araddr);
            en_d    = in_range(araddr);
            a_d     = word_addr(araddr);
          end
        end else begin
          arm = 1'b1;
        end
      end
      S_WR: begin
        state_d  = S_WRESP;
        bvalid_d = 1'b1;
        bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      S_WRESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
          arm      = 1'b1;
        end
      end
      S_RD: begin
        state_d = S_RCAP;
      end
      S_RCAP: begin
        state_d  = S_RRESP;
        rvalid_d = 1'b1;
        rdata_d  = err_q ? 32'h0 : bram_do;
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      S_RRESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
          arm      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arm) begin
      wr_rdy_d = pick_wr;
      ar_rdy_d = pick_rd;
      if (pick_wr) begin
        rr_d = RR_WRITE;
      end else if (pick_rd) begin
        rr_d = RR_READ;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= RR_READ;
      err_q    <= 1'b0;
      wr_rdy_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'h0;
      en_q     <= 1'b0;
      we_q     <= 4'h0;
      a_q      <= '0;
      di_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
      wr_rdy_q <= wr_rdy_d;
      ar_rdy_q <= ar_rdy_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      we_q     <= we_d;
      a_q      <= a_d;
      di_q     <= di_d;
    end
  end

  assign awready = wr_rdy_q;
  assign wready  = wr_rdy_q;
  assign arready = ar_rdy_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign bram_en = en_q;
  assign bram_we = we_q;
  assign bram_a  = a_q;
  assign bram_di = di_q;

endmodule

`default_nettype wire
